// File: rtl/mac_job_sequencer_pkg.sv
// rtl/mac_job_sequencer_pkg.sv - cfg field positions, mode codes and sequencer state type
package mac_job_sequencer_pkg;

  // cfg layout: [3]=signed, [2]=mac(1)/mul(0), [1:0]=mode
  localparam int CFG_SIGNED  = 3;
  localparam int CFG_MAC     = 2;
  localparam int CFG_MODE_HI = 1;
  localparam int CFG_MODE_LO = 0;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_DUAL   = 2'b01;
  localparam logic [1:0] MODE_QUAD   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // The reserved lane mode is run as single lane so the datapath never sees it
  function automatic logic [1:0] sanitize_mode(input logic [1:0] mode);
    return (mode == MODE_RSVD) ? MODE_SINGLE : mode;
  endfunction

  function automatic logic is_rsvd_mode(input logic [1:0] mode);
    return (mode == MODE_RSVD);
  endfunction

endpackage

// File: rtl/mac_seq_counter.sv
// rtl/mac_seq_counter.sv - loadable up/down counter used for beat and drain tracking
module mac_seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  // load wins over inc, inc wins over dec; everything frozen while en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      if (load) begin
        count <= load_val;
      end else if (inc) begin
        count <= count + W'(1);
      end else if (dec) begin
        count <= count - W'(1);
      end
    end
  end

endmodule

// File: rtl/mac_job_sequencer.sv
// rtl/mac_job_sequencer.sv - sequences one shared MAC datapath through accumulate jobs
module mac_job_sequencer
  import mac_job_sequencer_pkg::*;
#(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int LEN_W          = 8,
  parameter int PIPE_LAT       = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [MAC_CONF_WIDTH-1:0] cfg_in,
  input  logic [LEN_W-1:0]          len_in,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [MAC_CONF_WIDTH-1:0] mac_cfg,
  output logic                      mac_en,
  output logic                      acc_clr,
  output logic                      mac_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      cfg_err
);

  // Drain counter only needs to hold PIPE_LAT
  localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

  seq_state_t                state;
  seq_state_t                state_next;
  logic [LEN_W-1:0]          eff_len;
  logic [LEN_W-1:0]          job_len;
  logic [LEN_W-1:0]          beat_cnt;
  logic [DRAIN_W-1:0]        drain_cnt;
  logic [MAC_CONF_WIDTH-1:0] cfg_clean;
  logic                      cfg_fire;
  logic                      beat_fire;
  logic                      last_beat;
  logic                      drain_done;
  logic                      mac_en_q;
  logic                      acc_clr_q;
  logic                      mac_last_q;

  // cfg_ready/in_ready already include en, so these are true transfers only
  assign cfg_fire   = cfg_valid & cfg_ready;
  assign beat_fire  = in_valid & in_ready;
  assign last_beat  = (beat_cnt == eff_len - LEN_W'(1));
  assign drain_done = (drain_cnt == DRAIN_W'(1));

  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // A strobe captured just before en drops is held and presented once en returns,
  // so the datapath still sees every accepted beat exactly once
  assign mac_en   = mac_en_q & en;
  assign acc_clr  = acc_clr_q & en;
  assign mac_last = mac_last_q & en;

  // Clean the incoming job: reserved mode becomes single, mul jobs are one beat, len 0 means 1
  always_comb begin
    cfg_clean = cfg_in;
    cfg_clean[CFG_MODE_HI:CFG_MODE_LO] = sanitize_mode(cfg_in[CFG_MODE_HI:CFG_MODE_LO]);
    if (!cfg_in[CFG_MAC]) begin
      job_len = LEN_W'(1);
    end else if (len_in == '0) begin
      job_len = LEN_W'(1);
    end else begin
      job_len = len_in;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (en) begin
      state <= state_next;
    end
  end

  // Next-state and handshake readies; nothing is ready while en is low
  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    in_ready   = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE: begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          in_ready = 1'b1;
          if (in_valid && last_beat) begin
            state_next = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Job registers change only on accept, so mac_cfg is stable for the whole job
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_cfg <= '0;
      eff_len <= '0;
    end else if (cfg_fire) begin
      mac_cfg <= cfg_clean;
      eff_len <= job_len;
    end
  end

  // Datapath strobes follow the accepted beat by one cycle and freeze with en
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_en_q   <= 1'b0;
      acc_clr_q  <= 1'b0;
      mac_last_q <= 1'b0;
    end else if (en) begin
      mac_en_q   <= beat_fire;
      acc_clr_q  <= beat_fire && (beat_cnt == '0);
      mac_last_q <= beat_fire && last_beat;
    end
  end

  // Reserved-mode flag is a single-cycle pulse after the accepting cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_fire && is_rsvd_mode(cfg_in[CFG_MODE_HI:CFG_MODE_LO]);
    end
  end

  mac_seq_counter #(
    .W (LEN_W)
  ) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (cfg_fire),
    .load_val ('0),
    .inc      (beat_fire),
    .dec      (1'b0),
    .count    (beat_cnt)
  );

  mac_seq_counter #(
    .W (DRAIN_W)
  ) u_drain_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (beat_fire && last_beat),
    .load_val (DRAIN_W'(PIPE_LAT)),
    .inc      (1'b0),
    .dec      (state == ST_DRAIN),
    .count    (drain_cnt)
  );

endmodule

// File: tb/tb_mac_job_sequencer.sv
// tb/tb_mac_job_sequencer.sv - directed self-checking bench for mac_job_sequencer
module tb_mac_job_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] cfg_in;
  logic [7:0] len_in;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] mac_cfg;
  logic       mac_en;
  logic       acc_clr;
  logic       mac_last;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       cfg_err;

  int total = 0;
  int bad   = 0;

  // 10 ns clock
  always #5 clk = ~clk;

  mac_job_sequencer #(
    .MAC_CONF_WIDTH (4),
    .LEN_W          (8),
    .PIPE_LAT       (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_in    (cfg_in),
    .len_in    (len_in),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mac_cfg   (mac_cfg),
    .mac_en    (mac_en),
    .acc_clr   (acc_clr),
    .mac_last  (mac_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One job with back-to-back beats; DONE is expected 4 cycles after the last accept
  task automatic run_job(input string tag, input logic [3:0] cfg, input logic [7:0] len,
                         input int nbeats, input logic [3:0] exp_cfg, input logic exp_err,
                         input int hold);
    cfg_in = cfg; len_in = len; cfg_valid = 1'b1; #1;
    chk1({tag, "_cfg_ready"}, cfg_ready, 1'b1);
    tick;
    cfg_valid = 1'b0; cfg_in = 4'b0000; len_in = 8'd0;
    for (int i = 0; i < nbeats; i++) begin
      in_valid = 1'b1; #1;
      chk1({tag, "_in_ready"}, in_ready, 1'b1);
      chk4({tag, "_mac_cfg_run"}, mac_cfg, exp_cfg);
      chk1({tag, "_out_valid_run"}, out_valid, 1'b0);
      if (i == 0) begin
        chk1({tag, "_cfg_err"}, cfg_err, exp_err);
        chk1({tag, "_mac_en_first"}, mac_en, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b1);
      end else begin
        chk1({tag, "_mac_en"}, mac_en, 1'b1);
        chk1({tag, "_acc_clr"}, acc_clr, (i == 1));
        chk1({tag, "_mac_last"}, mac_last, 1'b0);
      end
      tick;
    end
    in_valid = 1'b0; #1;
    chk1({tag, "_mac_en_lastbeat"}, mac_en, 1'b1);
    chk1({tag, "_acc_clr_lastbeat"}, acc_clr, (nbeats == 1));
    chk1({tag, "_mac_last_lastbeat"}, mac_last, 1'b1);
    chk1({tag, "_in_ready_drain"}, in_ready, 1'b0);
    chk1({tag, "_cfg_err_gone"}, cfg_err, 1'b0);
    chk1({tag, "_out_valid_t1"}, out_valid, 1'b0);
    tick;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; #1;
      chk1({tag, "_in_ready_ignored"}, in_ready, 1'b0);
      chk1({tag, "_mac_en_drain"}, mac_en, 1'b0);
      chk1({tag, "_out_valid_drain"}, out_valid, 1'b0);
      tick;
    end
    in_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      cfg_valid = 1'b1; out_ready = 1'b0; #1;
      chk1({tag, "_out_valid_hold"}, out_valid, 1'b1);
      chk1({tag, "_cfg_ready_hold"}, cfg_ready, 1'b0);
      chk4({tag, "_mac_cfg_hold"}, mac_cfg, exp_cfg);
      tick;
    end
    cfg_valid = 1'b0; out_ready = 1'b1; #1;
    chk1({tag, "_out_valid_done"}, out_valid, 1'b1);
    chk1({tag, "_cfg_ready_done"}, cfg_ready, 1'b0);
    chk4({tag, "_mac_cfg_done"}, mac_cfg, exp_cfg);
    tick;
    out_ready = 1'b0; #1;
    chk1({tag, "_out_valid_after"}, out_valid, 1'b0);
    chk1({tag, "_busy_after"}, busy, 1'b0);
    chk4({tag, "_mac_cfg_after"}, mac_cfg, exp_cfg);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_in = 4'b0000; len_in = 8'd0;
    cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick;
    tick;

    // Reset state, en low
    rst = 1'b0; #1;
    chk4("rst_mac_cfg", mac_cfg, 4'b0000);
    chk1("rst_mac_en", mac_en, 1'b0);
    chk1("rst_acc_clr", acc_clr, 1'b0);
    chk1("rst_mac_last", mac_last, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_cfg_err", cfg_err, 1'b0);
    chk1("rst_cfg_ready_en0", cfg_ready, 1'b0);

    // Handshake with en low is not a transfer
    cfg_in = 4'b1110; len_in = 8'd4; cfg_valid = 1'b1;
    tick;
    #1;
    chk1("en0_no_accept_busy", busy, 1'b0);
    cfg_valid = 1'b0; en = 1'b1; #1;
    chk1("en1_cfg_ready", cfg_ready, 1'b1);

    run_job("quad", 4'b1110, 8'd4, 4, 4'b1110, 1'b0, 0);
    run_job("mul", 4'b0001, 8'd9, 1, 4'b0001, 1'b0, 0);
    run_job("len0", 4'b0100, 8'd0, 1, 4'b0100, 1'b0, 0);
    run_job("len255", 4'b1101, 8'd255, 255, 4'b1101, 1'b0, 0);
    run_job("rsvd", 4'b1111, 8'd2, 2, 4'b1100, 1'b1, 5);

    // en low for 2 cycles mid-RUN and 2 cycles mid-DRAIN, 3-beat unsigned MAC
    cfg_in = 4'b0100; len_in = 8'd3; cfg_valid = 1'b1; #1;
    chk1("enst_cfg_ready", cfg_ready, 1'b1);
    tick;
    cfg_valid = 1'b0; in_valid = 1'b1; #1;
    chk1("enst_in_ready_b0", in_ready, 1'b1);
    tick;
    en = 1'b0; #1;
    chk1("enst_in_ready_off1", in_ready, 1'b0);
    chk1("enst_mac_en_off1", mac_en, 1'b0);
    tick;
    #1;
    chk1("enst_in_ready_off2", in_ready, 1'b0);
    chk1("enst_mac_en_off2", mac_en, 1'b0);
    chk1("enst_busy_off2", busy, 1'b1);
    tick;
    en = 1'b1; #1;
    chk1("enst_in_ready_b1", in_ready, 1'b1);
    chk1("enst_mac_en_b0", mac_en, 1'b1);
    chk1("enst_acc_clr_b0", acc_clr, 1'b1);
    tick;
    #1;
    chk1("enst_mac_en_b1", mac_en, 1'b1);
    chk1("enst_acc_clr_b1", acc_clr, 1'b0);
    chk1("enst_mac_last_b1", mac_last, 1'b0);
    tick;
    in_valid = 1'b0; #1;
    chk1("enst_mac_last_b2", mac_last, 1'b1);
    chk1("enst_in_ready_drain", in_ready, 1'b0);
    tick;
    en = 1'b0; #1;
    chk1("enst_out_valid_d1", out_valid, 1'b0);
    tick;
    #1;
    chk1("enst_out_valid_d2", out_valid, 1'b0);
    tick;
    en = 1'b1; #1;
    chk1("enst_out_valid_d3", out_valid, 1'b0);
    tick;
    #1;
    chk1("enst_out_valid_d4", out_valid, 1'b0);
    tick;
    out_ready = 1'b1; #1;
    chk1("enst_out_valid_late", out_valid, 1'b1);
    tick;
    out_ready = 1'b0; #1;
    chk1("enst_out_valid_after", out_valid, 1'b0);
    chk1("enst_busy_after", busy, 1'b0);

    // Reset while draining aborts the job
    cfg_in = 4'b0110; len_in = 8'd1; cfg_valid = 1'b1; #1;
    tick;
    cfg_valid = 1'b0; in_valid = 1'b1; #1;
    chk1("rstd_in_ready", in_ready, 1'b1);
    tick;
    in_valid = 1'b0; #1;
    chk1("rstd_mac_last", mac_last, 1'b1);
    chk1("rstd_busy_drain", busy, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0; #1;
    chk4("rstd_mac_cfg", mac_cfg, 4'b0000);
    chk1("rstd_mac_en", mac_en, 1'b0);
    chk1("rstd_acc_clr", acc_clr, 1'b0);
    chk1("rstd_mac_last_clr", mac_last, 1'b0);
    chk1("rstd_out_valid", out_valid, 1'b0);
    chk1("rstd_busy", busy, 1'b0);
    chk1("rstd_cfg_err", cfg_err, 1'b0);
    chk1("rstd_cfg_ready", cfg_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick;
      #1;
      chk1("rstd_no_result", out_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
